// File: rtl/insn_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : insn_buffer_pkg
// Purpose  : Shared types for the fetch-to-decode instruction buffer.
//            Defines the address/code types and the per-parcel entry record
//            carried from fetch to decode.
// Revision : 1.0 - initial release
// ============================================================================
package insn_buffer_pkg;

    localparam int VADDR_WIDTH    = 32;
    localparam int PADDR_WIDTH    = 34;
    localparam int INT_CODE_WIDTH = 4;

    typedef logic [VADDR_WIDTH-1:0]    vaddr_t;
    typedef logic [PADDR_WIDTH-1:0]    paddr_t;
    typedef logic [INT_CODE_WIDTH-1:0] int_code_t;

    // One 16-bit instruction parcel plus its fetch-side attributes.
    typedef struct packed {
        logic [15:0] insn;
        vaddr_t      pc;
        paddr_t      pc_paddr_debug;
        logic        fault;
        logic        interrupt_valid;
        int_code_t   interrupt_code;
    } insn_buffer_entry_t;

endpackage
`default_nettype wire

// File: rtl/insn_buffer_storage.sv
`default_nettype none
// ============================================================================
// Module   : insn_buffer_storage
// Purpose  : DEPTH-entry register array with two write ports and two
//            asynchronous read ports. The caller guarantees the two write
//            indexes differ whenever both enables are set.
// Ports    : clk, rst            - clock, async active-high reset (clears array)
//            wr_en0/1, wr_idx0/1, wr_data0/1 - write ports
//            rd_idx0/1, rd_data0/1           - combinational read ports
// Revision : 1.0 - initial release
// ============================================================================
module insn_buffer_storage
    import insn_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en0,
    input  logic [PW-1:0]      wr_idx0,
    input  insn_buffer_entry_t wr_data0,
    input  logic               wr_en1,
    input  logic [PW-1:0]      wr_idx1,
    input  insn_buffer_entry_t wr_data1,
    input  logic [PW-1:0]      rd_idx0,
    input  logic [PW-1:0]      rd_idx1,
    output insn_buffer_entry_t rd_data0,
    output insn_buffer_entry_t rd_data1
);

    insn_buffer_entry_t r_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (wr_en0) begin
                r_mem[wr_idx0] <= wr_data0;
            end
            if (wr_en1) begin
                r_mem[wr_idx1] <= wr_data1;
            end
        end
    end

    assign rd_data0 = r_mem[rd_idx0];
    assign rd_data1 = r_mem[rd_idx1];

endmodule
`default_nettype wire

// File: rtl/insn_buffer.sv
`default_nettype none
// ============================================================================
// Module   : insn_buffer
// Purpose  : Halfword-granular instruction FIFO between fetch and decode.
//            Accepts up to two parcels per cycle, exposes the two oldest and
//            retires one or two per cycle. No write-to-read bypass.
// Ports    : clk, rst                      - clock, async active-high reset
//            flush                         - drop all entries next edge
//            write_low/high, write_entry_* - fetch-side push
//            writable_entry_count          - free slots (DEPTH - count)
//            read_low/high                 - decode-side pop (high needs low)
//            read_entry_low/high           - entries at head and head+1
//            readable_entry_count          - valid entries
// Revision : 1.0 - initial release
// ============================================================================
module insn_buffer
    import insn_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               write_low,
    input  logic               write_high,
    input  insn_buffer_entry_t write_entry_low,
    input  insn_buffer_entry_t write_entry_high,
    output logic [CW-1:0]      writable_entry_count,
    input  logic               read_low,
    input  logic               read_high,
    output insn_buffer_entry_t read_entry_low,
    output insn_buffer_entry_t read_entry_high,
    output logic [CW-1:0]      readable_entry_count
);

    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic [1:0]         w_pop_req;
    logic [1:0]         w_pops;
    logic [1:0]         w_push;
    logic               w_push_ok;
    logic [1:0]         w_push_acc;
    logic [CW-1:0]      w_free;
    logic               w_wr_en0;
    logic               w_wr_en1;
    insn_buffer_entry_t w_wr_data0;

    assign w_free = C_DEPTH - r_count;

    // read_high alone is ignored; pops are clamped to what is present.
    assign w_pop_req = {1'b0, read_low} + {1'b0, read_low & read_high};
    assign w_pops    = (CW'(w_pop_req) > r_count) ? r_count[1:0] : w_pop_req;

    // Admission uses the free space before this cycle's pops, and a push that
    // does not fit is dropped whole.
    assign w_push     = {1'b0, write_low} + {1'b0, write_high};
    assign w_push_ok  = (CW'(w_push) <= w_free);
    assign w_push_acc = w_push_ok ? w_push : 2'd0;

    // Port 0 always lands at tail: low if present, otherwise a lone high.
    // Port 1 is only used for the high half of a pair.
    assign w_wr_en0   = !flush && w_push_ok && (write_low || write_high);
    assign w_wr_en1   = !flush && w_push_ok && write_low && write_high;
    assign w_wr_data0 = write_low ? write_entry_low : write_entry_high;

    insn_buffer_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk      (clk),
        .rst      (rst),
        .wr_en0   (w_wr_en0),
        .wr_idx0  (r_tail),
        .wr_data0 (w_wr_data0),
        .wr_en1   (w_wr_en1),
        .wr_idx1  (r_tail + PW'(1)),
        .wr_data1 (write_entry_high),
        .rd_idx0  (r_head),
        .rd_idx1  (r_head + PW'(1)),
        .rd_data0 (read_entry_low),
        .rd_data1 (read_entry_high)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_pops);
            r_tail  <= r_tail + PW'(w_push_acc);
            r_count <= r_count - CW'(w_pops) + CW'(w_push_acc);
        end
    end

    assign readable_entry_count = r_count;
    assign writable_entry_count = w_free;

`ifdef INSN_BUFFER_PROTOCOL_CHECKS
    ap_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !flush |-> w_push_ok)
        else $error("insn_buffer: push dropped, not enough free slots");

    ap_no_overread: assert property (@(posedge clk) disable iff (rst)
        !flush |-> (CW'(w_pop_req) <= r_count))
        else $error("insn_buffer: pop exceeds readable entries");

    ap_high_needs_low: assert property (@(posedge clk) disable iff (rst)
        read_high |-> read_low)
        else $error("insn_buffer: read_high without read_low");
`endif

endmodule
`default_nettype wire

// File: tb/tb_insn_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_insn_buffer
// Purpose  : Self-checking bench for insn_buffer. A queue-based reference
//            model predicts buffer contents each cycle; predictions go to a
//            scoreboard queue that an independent monitor drains after every
//            clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_insn_buffer;
    import insn_buffer_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               write_low;
    logic               write_high;
    insn_buffer_entry_t write_entry_low;
    insn_buffer_entry_t write_entry_high;
    logic [CW-1:0]      writable_entry_count;
    logic               read_low;
    logic               read_high;
    insn_buffer_entry_t read_entry_low;
    insn_buffer_entry_t read_entry_high;
    logic [CW-1:0]      readable_entry_count;

    insn_buffer #(.DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush                (flush),
        .write_low            (write_low),
        .write_high           (write_high),
        .write_entry_low      (write_entry_low),
        .write_entry_high     (write_entry_high),
        .writable_entry_count (writable_entry_count),
        .read_low             (read_low),
        .read_high            (read_high),
        .read_entry_low       (read_entry_low),
        .read_entry_high      (read_entry_high),
        .readable_entry_count (readable_entry_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                 cnt;
        insn_buffer_entry_t low;
        insn_buffer_entry_t high;
    } exp_t;

    int                 total = 0;
    int                 bad   = 0;
    insn_buffer_entry_t model_q[$];
    exp_t               exp_q[$];
    logic [31:0]        next_pc = 32'h100;

    function automatic insn_buffer_entry_t mk_entry(input logic [31:0] pc);
        insn_buffer_entry_t e;
        e.insn            = 16'($urandom);
        e.pc              = pc;
        e.pc_paddr_debug  = {2'b10, pc ^ 32'h8000_0000};
        e.fault           = 1'($urandom_range(0, 1));
        e.interrupt_valid = 1'($urandom_range(0, 1));
        e.interrupt_code  = 4'($urandom_range(0, 15));
        return e;
    endfunction

    task automatic check_int(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_ent(input string name, input insn_buffer_entry_t act,
                             input insn_buffer_entry_t req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got insn=%h pc=%h f=%b iv=%b ic=%h expected insn=%h pc=%h f=%b iv=%b ic=%h at %0t",
                     name, act.insn, act.pc, act.fault, act.interrupt_valid, act.interrupt_code,
                     req.insn, req.pc, req.fault, req.interrupt_valid, req.interrupt_code, $time);
        end
    endtask

    // Drive one cycle of stimulus and record what the buffer must look like
    // after the coming edge. insn_ovr >= 0 forces the low parcel's insn.
    task automatic step(input logic wl, input logic wh, input logic rl,
                        input logic rh, input logic fl, input int insn_ovr = -1);
        insn_buffer_entry_t el, eh;
        exp_t               e;
        int                 n, req, pops, push;
        @(negedge clk);
        el = mk_entry(next_pc);
        eh = mk_entry(wl ? next_pc + 32'd2 : next_pc);
        if (insn_ovr >= 0) el.insn = 16'(insn_ovr);
        write_low        = wl;
        write_high       = wh;
        write_entry_low  = el;
        write_entry_high = eh;
        read_low         = rl;
        read_high        = rh;
        flush            = fl;

        n    = model_q.size();
        req  = rl ? (rh ? 2 : 1) : 0;
        pops = (req > n) ? n : req;
        push = int'(wl) + int'(wh);
        if (fl) begin
            model_q.delete();
        end else begin
            for (int i = 0; i < pops; i++) void'(model_q.pop_front());
            if (push <= DEPTH - n) begin
                if (wl) model_q.push_back(el);
                if (wh) model_q.push_back(eh);
                next_pc = next_pc + 32'(2 * push);
            end
        end

        e.cnt  = model_q.size();
        e.low  = (e.cnt >= 1) ? model_q[0] : '0;
        e.high = (e.cnt >= 2) ? model_q[1] : '0;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        write_low  = 1'b0;
        write_high = 1'b0;
        read_low   = 1'b0;
        read_high  = 1'b0;
        flush      = 1'b0;
    endtask

    // Scoreboard monitor: one prediction per clock edge.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_int("readable_count", int'(readable_entry_count), e.cnt);
            check_int("writable_count", int'(writable_entry_count), DEPTH - e.cnt);
            if (e.cnt >= 1) check_ent("read_entry_low", read_entry_low, e.low);
            if (e.cnt >= 2) check_ent("read_entry_high", read_entry_high, e.high);
        end
    end

    initial begin
        idle_inputs();
        write_entry_low  = '0;
        write_entry_high = '0;
        rst = 1'b1;
        #2;
        check_int("reset_readable", int'(readable_entry_count), 0);
        check_int("reset_writable", int'(writable_entry_count), DEPTH);
        check_ent("reset_low", read_entry_low, '0);
        check_ent("reset_high", read_entry_high, '0);
        #5 rst = 1'b0;

        // First push and its one-cycle visibility.
        next_pc = 32'h100;
        step(1, 0, 0, 0, 0, 16'h4501);
        @(posedge clk); #2;
        check_int("first_insn", int'(read_entry_low.insn), 16'h4501);
        step(0, 0, 1, 0, 0);

        // Pairs in order, then split pops.
        next_pc = 32'h100;
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 0, 0);
        @(posedge clk); #2;
        check_int("split_pop_pc", int'(read_entry_low.pc), 32'h106);

        // Fill to full, then overflow attempts and push+pop at full.
        step(0, 0, 0, 0, 1);
        repeat (4) step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        @(posedge clk); #2;
        check_int("full_push_pop_cnt", int'(readable_entry_count), 7);

        // Down to 5, then flush together with push and pop.
        step(0, 0, 1, 1, 0);
        step(1, 1, 1, 1, 1);

        // count 3, push 2 + pop 2 keeps count at 3.
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 0);
        @(posedge clk); #2;
        check_int("push2_pop2_cnt", int'(readable_entry_count), 3);

        // Streaming through the wrap point while always popping.
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                 1'($urandom_range(0, 1)), 1'b0);
        end

        // Fully random traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 29) == 0));
        end

        // Asynchronous reset mid-stream.
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        @(posedge clk); #2;
        idle_inputs();
        rst = 1'b1;
        #1;
        check_int("async_rst_readable", int'(readable_entry_count), 0);
        check_int("async_rst_writable", int'(writable_entry_count), DEPTH);
        check_ent("async_rst_low", read_entry_low, '0);
        rst = 1'b0;
        model_q.delete();

        // First push after reset release.
        step(1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #3;
        check_int("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/insn_buffer.md
# insn_buffer

Halfword-granular instruction FIFO between fetch and decode. The fetch stage pushes up to two 16-bit parcels per cycle, each tagged with PC, debug physical PC, page-fault and interrupt information. The decode stage sees the two oldest parcels and pops one (RVC) or two (32-bit instruction) per cycle.

## Interface
- DEPTH, 8: entry count; power of two, ≥4.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous discard of all entries.
- write_low  in  1  push write_entry_low.
- write_high  in  1  push write_entry_high, after low if both are set.
- write_entry_low, write_entry_high  in  InsnBufferEntry  parcels from fetch.
- writable_entry_count  out  $clog2(DEPTH)+1  free slots.
- read_low  in  1  pop the oldest entry.
- read_high  in  1  pop the second-oldest entry; legal only with read_low.
- read_entry_low, read_entry_high  out  InsnBufferEntry  entries at head and head+1.
- readable_entry_count  out  $clog2(DEPTH)+1  valid entries.

InsnBufferEntry fields:
- insn[15:0]
- pc (vaddr_t)
- pc_paddr_debug (paddr_t)
- fault
- interruptValid
- interruptCode

## Operation
- State:
  - head and tail pointers, $clog2(DEPTH) bits each; they wrap modulo DEPTH naturally.
  - count register, 0..DEPTH.
  - storage array.
- Outputs derived from registered state:
  - readable_entry_count = count.
  - writable_entry_count = DEPTH − count.
  - No write→read bypass.
- Read ports:
  - read_entry_low = mem[head].
  - read_entry_high = mem[head+1 mod DEPTH].
  - Contents beyond count are stale data; the consumer qualifies them with readable_entry_count.
- Pop amount: pops = read_low + (read_low & read_high), clamped to count.
  - read_high without read_low pops nothing.
  - An over-read is clamped and flagged by assertion.
- Push order:
  - push = write_low + write_high.
  - Low goes to mem[tail], high to the next slot.
  - If only write_high is set, the high entry goes to mem[tail].
- Push admission:
  - A push is accepted only if push ≤ writable_entry_count as sampled this cycle, before same-cycle pops.
  - Otherwise the entire push is dropped (no partial write) and an assertion fires.
- Simultaneous push and pop:
  - Both take effect.
  - count_next = count − pops + push_accepted.
  - The head and tail updates are independent.
- Flush:
  - head, tail and count go to 0 on the next edge.
  - Flush overrides same-cycle push and pop.
  - Storage is not cleared.
- Reset: head, tail, count and all storage go to 0 immediately on rst assertion.

## Timing
- Write-to-read latency is 1 cycle: an entry pushed at edge N is visible on read_entry_* and counted in readable_entry_count after edge N.
- Pop takes effect at the edge: after popping 1 at edge N, read_entry_low shows the former read_entry_high.
- Reset values:
  - readable_entry_count = 0.
  - writable_entry_count = DEPTH.
  - read_entry_low and read_entry_high = 0.
- Full (count = DEPTH): writable_entry_count = 0 and every push is dropped. A same-cycle pop does not free space for that cycle's push.
- Empty: any pop is ignored; count stays 0.
- rst asserted mid-operation clears state asynchronously. The first push is accepted on the first edge after deassertion.

## Structure
- Add InsnBufferEntry to the shared RafiTypes package; reuse vaddr_t, paddr_t and the exception/interrupt code types from RvTypes.
- Wrap the ports in an interface with modports FetchStage, DecodeStage and InsnBuffer. Signal names follow the existing readEntryLow, readLow and readableEntryCount style on that interface.
- One natural sub-module: insn_buffer_storage, the DEPTH-entry register array with 2 write ports (indexes tail and tail+1) and 2 read ports (indexes head and head+1). Pointer and count logic stays in the top level.

## Test plan
- Reset then idle:
  - counts are 0/8 and read entries are 0.
  - Push low {insn=16'h4501, pc=0x100}: the next cycle readable=1 and read_entry_low.insn=16'h4501.
- Pairs in order, then split pops:
  - Push pairs (0x100,0x102), (0x104,0x106): readable=4.
  - Pop 2: low pc=0x104.
  - Pop 1: low pc=0x106, readable=1.
- Fill to full:
  - 4 pair-pushes reach count=8, writable=0.
  - A further push is dropped: count stays 8 and head data is unchanged.
- Wrap-around:
  - Stream 20 sequential parcels (pc step 2) while popping 1–2 per cycle.
  - Every parcel exits in pc order with its fault and interrupt bits intact.
  - read_entry_high is correct when head=7 (it reads slot 0).
- Simultaneous events:
  - At count=3, push 2 and pop 2 in the same cycle: count=3 afterwards.
  - At count=8, push 1 and pop 1: the push is dropped and count=7.
- Flush and reset:
  - With count=5, asserting flush together with push/pop gives count=0 next cycle.
  - Asserting rst asynchronously mid-stream makes the counts read 0/8 before the next edge.
